// File: rtl/onehot2code_sync.sv
// Synchronised one-hot to code encoder with stability filter and a valid/ready change event.
// Latency: input sampled at edge k -> cur_* at k+2+STABLE_CYCLES, ev_valid at k+3+STABLE_CYCLES.
module onehot2code_sync #(
  parameter int               N_IN          = 10,
  parameter int               OUT_W         = 8,
  parameter int               STABLE_CYCLES = 16,
  parameter int               MODE          = 0,
  parameter logic [OUT_W-1:0] NONE_CODE     = OUT_W'(8'h0F),
  parameter logic [OUT_W-1:0] ERR_CODE      = OUT_W'(8'h0F)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  in_data,
  output logic [OUT_W-1:0] cur_code,
  output logic             cur_none,
  output logic             cur_err,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [OUT_W-1:0] ev_code
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  typedef struct packed {
    logic [OUT_W-1:0] code;
    logic             none;
    logic             err;
  } cand_t;

  localparam cand_t CAND_NONE = '{code: NONE_CODE, none: 1'b1, err: 1'b0};

  typedef enum logic {IDLE, PEND} state_t;

  logic [N_IN-1:0]  s1, s2;
  cand_t            cand, enc_nxt, stable, last_sent, ev_val;
  logic [CNT_W-1:0] cnt;
  logic             cand_chg;
  logic             multi_hot;
  logic [OUT_W-1:0] low_code;
  state_t           state, state_nxt;
  logic             ev_load, ev_accept;

  // Descending scan so the last hit written is the lowest set index.
  always_comb begin
    low_code = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (s2[i]) low_code = OUT_W'(i + 1);
    end
  end

  assign multi_hot = |(s2 & (s2 - N_IN'(1)));

  always_comb begin
    enc_nxt = CAND_NONE;
    if (|s2) begin
      if (multi_hot && (MODE == 0)) begin
        enc_nxt = '{code: ERR_CODE, none: 1'b0, err: 1'b1};
      end else begin
        enc_nxt = '{code: low_code, none: 1'b0, err: 1'b0};
      end
    end
  end

  assign cand_chg = (enc_nxt != cand);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      cand   <= CAND_NONE;
      cnt    <= '0;
      stable <= CAND_NONE;
    end else begin
      s1   <= in_data;
      s2   <= s1;
      cand <= enc_nxt;
      if (cand_chg) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (!cand_chg && (cnt == CNT_MAX)) begin
        stable <= cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ev_load   = 1'b0;
    ev_accept = 1'b0;
    case (state)
      IDLE: begin
        if (stable != last_sent) begin
          state_nxt = PEND;
          ev_load   = 1'b1;
        end
      end
      PEND: begin
        if (ev_ready) begin
          state_nxt = IDLE;
          ev_accept = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ev_val is frozen while pending; later stable changes only show on cur_*.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ev_val    <= CAND_NONE;
      last_sent <= CAND_NONE;
    end else begin
      state <= state_nxt;
      if (ev_load)   ev_val    <= stable;
      if (ev_accept) last_sent <= ev_val;
    end
  end

  assign cur_code = stable.code;
  assign cur_none = stable.none;
  assign cur_err  = stable.err;
  assign ev_valid = (state == PEND);
  assign ev_code  = ev_val.code;

endmodule

// File: tb/tb_onehot2code_sync.sv
// Bench: three configurations (strict, priority, small 4-in/STABLE=1) against a sample-history model.
module tb_onehot2code_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       ev_ready = 1'b1;
  logic [9:0] din = '0;
  logic [3:0] din2 = '0;

  logic [7:0] cc [3];
  logic [7:0] ec [3];
  logic       cn [3];
  logic       ce [3];
  logic       ev [3];
  logic [2:0] cc2, ec2;

  assign cc[2] = {5'b0, cc2};
  assign ec[2] = {5'b0, ec2};

  onehot2code_sync #(.MODE(0)) d0 (
    .clk(clk), .rst(rst), .in_data(din), .cur_code(cc[0]), .cur_none(cn[0]), .cur_err(ce[0]),
    .ev_valid(ev[0]), .ev_ready(ev_ready), .ev_code(ec[0]));

  onehot2code_sync #(.MODE(1)) d1 (
    .clk(clk), .rst(rst), .in_data(din), .cur_code(cc[1]), .cur_none(cn[1]), .cur_err(ce[1]),
    .ev_valid(ev[1]), .ev_ready(ev_ready), .ev_code(ec[1]));

  onehot2code_sync #(.N_IN(4), .OUT_W(3), .STABLE_CYCLES(1), .MODE(0),
                     .NONE_CODE(3'h7), .ERR_CODE(3'h6)) d2 (
    .clk(clk), .rst(rst), .in_data(din2), .cur_code(cc2), .cur_none(cn[2]), .cur_err(ce[2]),
    .ev_valid(ev[2]), .ev_ready(ev_ready), .ev_code(ec2));

  typedef struct packed {
    logic [7:0] code;
    logic       none;
    logic       err;
  } tup_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int stab(int d);
    return (d == 2) ? 1 : 16;
  endfunction

  function automatic tup_t none_t(int d);
    tup_t t;
    t.code = (d == 2) ? 8'h07 : 8'h0F;
    t.none = 1'b1;
    t.err  = 1'b0;
    return t;
  endfunction

  // Encoding rules from the block description, evaluated directly on an input word.
  function automatic tup_t enc(int d, logic [9:0] x);
    tup_t t;
    int n, ones, low;
    n = (d == 2) ? 4 : 10;
    ones = 0;
    low = -1;
    for (int i = 0; i < n; i++) begin
      if (x[i]) begin
        ones++;
        if (low < 0) low = i;
      end
    end
    if (ones == 0) begin
      t = none_t(d);
    end else if (ones == 1 || d == 1) begin
      t.code = 8'(low + 1);
      t.none = 1'b0;
      t.err  = 1'b0;
    end else begin
      t.code = (d == 2) ? 8'h06 : 8'h0F;
      t.none = 1'b0;
      t.err  = 1'b1;
    end
    return t;
  endfunction

  // Model: an encoded sample is accepted as stable once it has been seen STABLE+1
  // times in a row; it emerges two samples late because of the synchroniser.
  tup_t h_new [3];
  tup_t h_old [3];
  tup_t run_val [3];
  int   run_len [3];
  tup_t m_cur [3];
  tup_t m_last [3];
  tup_t m_ev [3];
  bit   m_pend [3];
  bit   armed = 1'b0;

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      tup_t oldest;
      if (rst) begin
        h_new[d]   = none_t(d);
        h_old[d]   = none_t(d);
        run_val[d] = none_t(d);
        run_len[d] = 1;
        m_cur[d]   = none_t(d);
        m_last[d]  = none_t(d);
        m_ev[d]    = none_t(d);
        m_pend[d]  = 1'b0;
      end else begin
        if (!m_pend[d]) begin
          if (m_cur[d] != m_last[d]) begin
            m_pend[d] = 1'b1;
            m_ev[d]   = m_cur[d];
          end
        end else if (ev_ready) begin
          m_pend[d] = 1'b0;
          m_last[d] = m_ev[d];
        end
        oldest   = h_old[d];
        h_old[d] = h_new[d];
        h_new[d] = enc(d, (d == 2) ? {6'b0, din2} : din);
        if (oldest == run_val[d]) begin
          if (run_len[d] < 1000) run_len[d]++;
        end else begin
          run_val[d] = oldest;
          run_len[d] = 1;
        end
        if (run_len[d] >= stab(d) + 1) m_cur[d] = run_val[d];
      end
    end
    if (rst) armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("d%0d cur_code", d), cc[d], m_cur[d].code);
        chk($sformatf("d%0d cur_none", d), 8'(cn[d]), 8'(m_cur[d].none));
        chk($sformatf("d%0d cur_err", d), 8'(ce[d]), 8'(m_cur[d].err));
        chk($sformatf("d%0d ev_valid", d), 8'(ev[d]), 8'(m_pend[d]));
        chk($sformatf("d%0d ev_code", d), ec[d], m_ev[d].code);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    tick(2);
    chk("rst cur_code", cc[0], 8'h0F);
    chk("rst cur_none", 8'(cn[0]), 8'h01);
    chk("rst ev_valid", 8'(ev[0]), 8'h00);
    chk("rst ev_code", ec[0], 8'h0F);
    chk("rst d2 cur_code", cc[2], 8'h07);
    rst = 1'b0;
    tick(3);

    // Basic latency: sampled at edge k
    din = 10'h004;
    din2 = 4'h8;
    tick(4);
    chk("small cur_code k+3", cc[2], 8'h04);
    chk("small ev_valid k+3", 8'(ev[2]), 8'h00);
    tick(1);
    chk("small ev_valid k+4", 8'(ev[2]), 8'h01);
    chk("small ev_code k+4", ec[2], 8'h04);
    tick(13);
    chk("basic cur_code k+17", cc[0], 8'h0F);
    tick(1);
    chk("basic cur_code k+18", cc[0], 8'h03);
    chk("basic ev_valid k+18", 8'(ev[0]), 8'h00);
    tick(1);
    chk("basic ev_valid k+19", 8'(ev[0]), 8'h01);
    chk("basic ev_code k+19", ec[0], 8'h03);
    tick(1);
    chk("basic ev_valid k+20", 8'(ev[0]), 8'h00);

    // Glitch every 10 cycles keeps the filter from settling
    din = '0;
    tick(30);
    for (int i = 0; i < 6; i++) begin
      din = 10'h004;
      tick(9);
      din = '0;
      tick(1);
    end
    chk("glitch cur_code", cc[0], 8'h0F);
    chk("glitch cur_none", 8'(cn[0]), 8'h01);
    din = 10'h004;
    tick(30);
    chk("glitch-free cur_code", cc[0], 8'h03);

    // Multi-hot in strict vs priority mode
    ev_ready = 1'b0;
    din = 10'h005;
    din2 = 4'h3;
    tick(30);
    chk("strict cur_err", 8'(ce[0]), 8'h01);
    chk("strict ev_code", ec[0], 8'h0F);
    chk("strict ev_valid", 8'(ev[0]), 8'h01);
    chk("prio cur_code", cc[1], 8'h01);
    chk("prio cur_err", 8'(ce[1]), 8'h00);
    chk("prio ev_code", ec[1], 8'h01);
    chk("small err code", ev[2] ? ec[2] : 8'hFF, 8'h06);
    ev_ready = 1'b1;
    tick(1);
    ev_ready = 1'b0;
    tick(2);

    // Changes during a pending event do not alter ev_code
    din = 10'h001;
    tick(30);
    din = 10'h200;
    tick(30);
    chk("pend ev_code held", ec[0], 8'h01);
    chk("pend ev_valid", 8'(ev[0]), 8'h01);
    chk("pend cur_code", cc[0], 8'h0A);
    ev_ready = 1'b1;
    tick(1);
    ev_ready = 1'b0;
    chk("accept ev_valid", 8'(ev[0]), 8'h00);
    tick(1);
    chk("re-event ev_valid", 8'(ev[0]), 8'h01);
    chk("re-event ev_code", ec[0], 8'h0A);
    ev_ready = 1'b1;
    tick(2);
    ev_ready = 1'b0;

    // Reset while pending
    din = 10'h004;
    tick(25);
    chk("pre-rst ev_valid", 8'(ev[0]), 8'h01);
    chk("pre-rst ev_code", ec[0], 8'h03);
    rst = 1'b1;
    tick(1);
    chk("mid-rst ev_valid", 8'(ev[0]), 8'h00);
    chk("mid-rst cur_code", cc[0], 8'h0F);
    rst = 1'b0;
    tick(18);
    chk("post-rst ev_valid r+18", 8'(ev[0]), 8'h00);
    tick(1);
    chk("post-rst cur_code r+19", cc[0], 8'h03);
    chk("post-rst ev_valid r+19", 8'(ev[0]), 8'h00);
    tick(1);
    chk("post-rst ev_valid r+20", 8'(ev[0]), 8'h01);
    chk("post-rst ev_code r+20", ec[0], 8'h03);
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
